// File: rtl/pll_reset_seq.sv
// Reset sequencer behind the PLL: debounces lock, pulses the PLL steady-lock reset,
// holds downstream reset for a fixed time and re-sequences on any loss of lock.
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int STDY_RST_CYCLES    = 4
) (
  input  logic       clock_in,
  input  logic       rst_in,
  input  logic       pll_locked,
  output logic       rst_out,
  output logic       ready,
  output logic       lock_stdy_rst,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state_dbg
);

  localparam int MAX_AB = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int MAX_C  = (MAX_AB > STDY_RST_CYCLES) ? MAX_AB : STDY_RST_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] STDY_LAST = CW'(STDY_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STDY = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10,
    ST_RUN  = 2'b11
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic          loss;

  always_ff @(posedge clock_in) begin
    if (rst_in) sync_q <= '0;
    else        sync_q <= {sync_q[0], pll_locked};
  end

  assign locked_s = sync_q[1];

  // STDY_RST waits one edge out of rst_in (lock_stdy_rst still low) before
  // counting, so the pulse is the same width whether entered from reset or
  // from a loss in RUN, where the entry edge already raises it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    loss    = 1'b0;
    case (state)
      ST_STDY: begin
        if (lock_stdy_rst) begin
          if (cnt == STDY_LAST) begin
            state_n = ST_WAIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!locked_s) begin
          cnt_n = '0;
        end else if (cnt == LOCK_LAST) begin
          state_n = ST_HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n = ST_STDY;
          loss    = 1'b1;
        end
      end
      default: begin
        state_n = ST_STDY;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as state.
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state           <= ST_STDY;
      cnt             <= '0;
      rst_out         <= 1'b1;
      ready           <= 1'b0;
      lock_stdy_rst   <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      rst_out       <= (state_n != ST_RUN);
      ready         <= (state_n == ST_RUN);
      lock_stdy_rst <= (state_n == ST_STDY);
      if (loss && (lock_loss_count != 8'hFF))
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_STABLE=8, RST_HOLD=4, STDY_RST=2.
module tb_pll_reset_seq;

  logic       clock_in = 1'b0;
  logic       rst_in, pll_locked;
  logic       rst_out, ready, lock_stdy_rst;
  logic [7:0] lock_loss_count;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES(8),
    .RST_HOLD_CYCLES   (4),
    .STDY_RST_CYCLES   (2)
  ) dut (
    .clock_in       (clock_in),
    .rst_in         (rst_in),
    .pll_locked     (pll_locked),
    .rst_out        (rst_out),
    .ready          (ready),
    .lock_stdy_rst  (lock_stdy_rst),
    .lock_loss_count(lock_loss_count),
    .state_dbg      (state_dbg)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       e_rst;
    logic       e_rdy;
    logic       e_lsr;
    logic [1:0] e_st;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mkv(logic r, logic l, logic er, logic ed, logic es, logic [1:0] st, logic [7:0] c);
    vec_t v;
    v.rst = r; v.lock = l; v.e_rst = er; v.e_rdy = ed; v.e_lsr = es; v.e_st = st; v.e_cnt = c;
    return v;
  endfunction

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic step(input logic r, input logic l);
    rst_in = r;
    pll_locked = l;
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string nm, input logic er, input logic ed, input logic es,
                       input logic [1:0] st, input logic [7:0] c);
    checks++;
    if ({rst_out, ready, lock_stdy_rst, state_dbg, lock_loss_count} !== {er, ed, es, st, c}) begin
      errors++;
      $display("FAIL %s: got rst_out=%b ready=%b lsr=%b state=%b cnt=%0d, expected rst_out=%b ready=%b lsr=%b state=%b cnt=%0d",
               nm, rst_out, ready, lock_stdy_rst, state_dbg, lock_loss_count, er, ed, es, st, c);
    end
  endtask

  // Loss at edge q, then 16 edges of lock: back in RUN at q+2+2+8+4.
  task automatic lose_and_recover();
    step(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    rst_in = 1'b1;
    pll_locked = 1'b1;

    // Power-up with lock high: reset 5 edges, then edges 1..16 after release.
    for (int i = 0; i < 5; i++) vecs[i] = mkv(1, 1, 1, 0, 0, 2'b00, 0);
    vecs[5]  = mkv(0, 1, 1, 0, 1, 2'b00, 0);   // edge 1: pulse starts
    vecs[6]  = mkv(0, 1, 1, 0, 1, 2'b00, 0);   // edge 2
    vecs[7]  = mkv(0, 1, 1, 0, 0, 2'b01, 0);   // edge 3: WAIT_LOCK
    for (int i = 8; i < 15; i++) vecs[i] = mkv(0, 1, 1, 0, 0, 2'b01, 0);
    vecs[15] = mkv(0, 1, 1, 0, 0, 2'b10, 0);   // edge 11: HOLD
    for (int i = 16; i < 19; i++) vecs[i] = mkv(0, 1, 1, 0, 0, 2'b10, 0);
    vecs[19] = mkv(0, 1, 0, 1, 0, 2'b11, 0);   // edge 15 = 14 edges after edge 1
    vecs[20] = mkv(0, 1, 0, 1, 0, 2'b11, 0);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].lock);
      check($sformatf("powerup[%0d]", i), vecs[i].e_rst, vecs[i].e_rdy, vecs[i].e_lsr,
            vecs[i].e_st, vecs[i].e_cnt);
    end

    // Single-cycle glitch in RUN.
    step(0, 0);
    step(0, 1); check("loss_sync_delay", 0, 1, 0, 2'b11, 0);
    step(0, 1); check("loss_enter",      1, 0, 1, 2'b00, 1);
    step(0, 1); check("loss_pulse2",     1, 0, 1, 2'b00, 1);
    step(0, 1); check("loss_wait",       1, 0, 0, 2'b01, 1);
    for (int i = 0; i < 11; i++) step(0, 1);
    check("loss_hold_last", 1, 0, 0, 2'b10, 1);
    step(0, 1); check("loss_rerelease", 0, 1, 0, 2'b11, 1);

    // Late lock: 20 cycles unlocked in WAIT_LOCK, then lock rises.
    for (int i = 0; i < 3; i++) step(1, 0);
    check("late_reset", 1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 20; i++) step(0, 0);
    check("late_waiting", 1, 0, 0, 2'b01, 0);
    for (int k = 0; k <= 13; k++) begin
      step(0, 1);
      if (k == 12) check("late_hold_last", 1, 0, 0, 2'b10, 0);
      if (k == 13) check("late_release",   0, 1, 0, 2'b11, 0);
    end

    // Debounce: 6 high, 1 low, then high; HOLD only after 8 consecutive synced highs.
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 3; i++) step(0, 0);
    check("deb_wait", 1, 0, 0, 2'b01, 0);
    for (int k = 0; k <= 16; k++) begin
      step(0, (k == 6) ? 1'b0 : 1'b1);
      if (k < 16) check($sformatf("deb_k%0d", k), 1, 0, 0, 2'b01, 0);
      else        check("deb_hold", 1, 0, 0, 2'b10, 0);
    end

    // Drop during HOLD: back to WAIT_LOCK, no loss counted, release 12 edges later.
    step(0, 0); check("hdrop_a", 1, 0, 0, 2'b10, 0);
    step(0, 1); check("hdrop_b", 1, 0, 0, 2'b10, 0);
    step(0, 1); check("hdrop_wait", 1, 0, 0, 2'b01, 0);
    for (int i = 0; i < 11; i++) step(0, 1);
    check("hdrop_hold_last", 1, 0, 0, 2'b10, 0);
    step(0, 1); check("hdrop_release", 0, 1, 0, 2'b11, 0);

    // Saturation of the loss counter.
    for (int n = 1; n <= 260; n++) begin
      lose_and_recover();
      if (n == 1 || n == 2 || n == 254 || n == 255 || n == 256 || n == 260)
        check($sformatf("sat_n%0d", n), 0, 1, 0, 2'b11, (n > 255) ? 8'd255 : 8'(n));
    end

    // rst_in mid-HOLD wins on the next edge and clears the count.
    step(0, 0);
    for (int i = 0; i < 13; i++) step(0, 1);
    check("prio_in_hold", 1, 0, 0, 2'b10, 255);
    step(1, 1); check("prio_reset", 1, 0, 0, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
